// File: rtl/al422_frame_writer_if.sv
// Pixel-pair stream into the AL422 frame writer: valid/ready handshake, one upper/lower pair per transfer.
interface al422_frame_writer_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [23:0] pix_rgb1;
  logic [23:0] pix_rgb2;

  modport master (output pix_valid, output pix_rgb1, output pix_rgb2, input pix_ready);
  modport slave  (input pix_valid, input pix_rgb1, input pix_rgb2, output pix_ready);
endinterface

// File: rtl/al422_frame_writer.sv
// AL422 write side: /WRST pulse per frame, then 6 bytes per pixel pair (R1,G1,B1,R2,G2,B2), R1 one cycle after transfer.
// Accepts a pair only in WAIT or on the last byte of the previous pair; frame_start aborts and wins over any transfer.
module al422_frame_writer #(
  parameter int PAIRS_PER_FRAME = 4096,
  parameter int CNT_W           = 12,
  parameter int WRST_CYCLES     = 2
) (
  input  logic                 in_clk,
  input  logic                 in_nrst,
  input  logic                 frame_start,
  al422_frame_writer_if.slave  pix,
  output logic [7:0]           fifo_data,
  output logic                 fifo_nwe,
  output logic                 fifo_nwrst,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int WW = (WRST_CYCLES > 1) ? $clog2(WRST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(PAIRS_PER_FRAME - 1);
  localparam logic [WW-1:0]    WRST_LAST = WW'(WRST_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRST,
    ST_WAIT,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       phase, phase_nxt;
  logic [CNT_W-1:0] pair_cnt, pair_cnt_nxt;
  logic [WW-1:0]    wrst_cnt, wrst_cnt_nxt;
  logic [39:0]      pair, pair_nxt;
  logic [7:0]       data_nxt;
  logic             nwe_nxt, nwrst_nxt, done_nxt;
  logic             last_phase, last_pair, xfer;

  assign last_phase = (phase == 3'd5);
  assign last_pair  = (pair_cnt == LAST_PAIR);
  assign busy       = (state != ST_IDLE);

  assign pix.pix_ready = !frame_start &&
                         ((state == ST_WAIT) ||
                          (state == ST_SEND && last_phase && !last_pair));
  assign xfer = pix.pix_valid && pix.pix_ready;

  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      state      <= ST_IDLE;
      phase      <= '0;
      pair_cnt   <= '0;
      wrst_cnt   <= '0;
      pair       <= '0;
      fifo_data  <= '0;
      fifo_nwe   <= 1'b1;
      fifo_nwrst <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      pair_cnt   <= pair_cnt_nxt;
      wrst_cnt   <= wrst_cnt_nxt;
      pair       <= pair_nxt;
      fifo_data  <= data_nxt;
      fifo_nwe   <= nwe_nxt;
      fifo_nwrst <= nwrst_nxt;
      frame_done <= done_nxt;
    end
  end

  // Outputs are computed one cycle ahead so every AL422 pin comes straight from a flop.
  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    pair_cnt_nxt = pair_cnt;
    wrst_cnt_nxt = wrst_cnt;
    pair_nxt     = pair;
    data_nxt     = fifo_data;
    nwe_nxt      = 1'b1;
    nwrst_nxt    = 1'b1;
    done_nxt     = 1'b0;

    if (frame_start) begin
      state_nxt    = ST_WRST;
      wrst_cnt_nxt = '0;
      pair_cnt_nxt = '0;
      nwrst_nxt    = 1'b0;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_WRST: begin
          pair_cnt_nxt = '0;
          if (wrst_cnt == WRST_LAST) begin
            state_nxt = ST_WAIT;
          end else begin
            wrst_cnt_nxt = wrst_cnt + WW'(1);
            nwrst_nxt    = 1'b0;
          end
        end
        ST_WAIT: ;
        ST_SEND: begin
          if (!last_phase) begin
            phase_nxt = phase + 3'd1;
            data_nxt  = pair[7:0];
            pair_nxt  = {8'h00, pair[39:8]};
            nwe_nxt   = 1'b0;
          end else if (last_pair) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
          end else begin
            pair_cnt_nxt = pair_cnt + CNT_W'(1);
            state_nxt    = ST_WAIT;
          end
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase

      // A transfer can only happen in WAIT or on phase 5, so it overrides the fallback to WAIT.
      if (xfer) begin
        state_nxt = ST_SEND;
        phase_nxt = '0;
        pair_nxt  = {pix.pix_rgb2, pix.pix_rgb1[23:8]};
        data_nxt  = pix.pix_rgb1[7:0];
        nwe_nxt   = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_al422_frame_writer.sv
// Directed frame sequence with random pixel data and valid gaps, checked against a cycle-stamped byte model.
module tb_al422_frame_writer;
  localparam int PAIRS = 5;
  localparam int WRST  = 2;

  logic       in_clk = 1'b0;
  logic       in_nrst;
  logic       frame_start;
  logic [7:0] fifo_data;
  logic       fifo_nwe, fifo_nwrst, busy, frame_done;

  al422_frame_writer_if pix ();

  al422_frame_writer #(
    .PAIRS_PER_FRAME(PAIRS),
    .CNT_W          (3),
    .WRST_CYCLES    (WRST)
  ) dut (
    .in_clk     (in_clk),
    .in_nrst    (in_nrst),
    .frame_start(frame_start),
    .pix        (pix),
    .fifo_data  (fifo_data),
    .fifo_nwe   (fifo_nwe),
    .fifo_nwrst (fifo_nwrst),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 in_clk = ~in_clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int         exp_c[$];
  logic [7:0] exp_d[$];
  int         cap_c[$];
  logic [7:0] cap_d[$];
  int         done_c[$];

  always @(posedge in_clk) cyc <= cyc + 1;

  always @(negedge in_clk) begin
    if (in_nrst) begin
      if (!fifo_nwe) begin
        cap_c.push_back(cyc);
        cap_d.push_back(fifo_data);
      end
      if (frame_done) done_c.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered and left just after a rising edge. Expected byte n of a pair accepted in cycle t lands in cycle t+1+n.
  task automatic run_frame(input bit gaps, input bit abort, input logic [23:0] r1, input logic [23:0] r2);
    int acc, last, s, ready_from, n;
    bit need_new;
    logic [47:0] w;
    acc = 0;
    last = -100;
    need_new = 0;
    frame_start = 1'b1;
    pix.pix_valid = 1'b1;
    pix.pix_rgb1 = r1;
    pix.pix_rgb2 = r2;
    @(negedge in_clk);
    check("ready_during_start", pix.pix_ready, 1'b0);
    s = cyc;
    ready_from = s + 1 + WRST;
    @(posedge in_clk); #1;
    frame_start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (acc == PAIRS && cyc > last + 9) break;
      if (abort && acc == 2 && cyc == last + 4) begin
        while (exp_c.size() > 0 && exp_c[$] > cyc) begin
          void'(exp_c.pop_back());
          void'(exp_d.pop_back());
        end
        return;
      end
      if (need_new) begin
        need_new = 0;
        if (gaps && $urandom_range(2, 0) == 0) pix.pix_valid = 1'b0;
        else begin
          pix.pix_valid = 1'b1;
          pix.pix_rgb1 = 24'($urandom);
          pix.pix_rgb2 = 24'($urandom);
        end
      end else if (!pix.pix_valid && $urandom_range(1, 0) == 1) begin
        pix.pix_valid = 1'b1;
        pix.pix_rgb1 = 24'($urandom);
        pix.pix_rgb2 = 24'($urandom);
      end
      @(negedge in_clk);
      check("nwrst", fifo_nwrst, !(cyc > s && cyc <= s + WRST));
      check("ready", pix.pix_ready, (acc < PAIRS && cyc >= ready_from));
      check("busy", busy, !(acc == PAIRS && cyc > last + 7));
      if (pix.pix_valid && pix.pix_ready) begin
        w = {pix.pix_rgb2, pix.pix_rgb1};
        for (int j = 0; j < 6; j++) begin
          exp_c.push_back(cyc + 1 + j);
          exp_d.push_back(w[8*j +: 8]);
        end
        last = cyc;
        acc++;
        ready_from = cyc + 6;
        need_new = 1;
      end
      @(posedge in_clk); #1;
    end
    check("pairs_accepted", acc, PAIRS);
    check("byte_count", cap_c.size(), exp_c.size());
    n = (cap_c.size() < exp_c.size()) ? cap_c.size() : exp_c.size();
    for (int i = 0; i < n; i++) begin
      check("byte_cycle", cap_c[i], exp_c[i]);
      check("byte_data", cap_d[i], exp_d[i]);
    end
    check("done_count", done_c.size(), 1);
    if (done_c.size() > 0) check("done_cycle", done_c[0], last + 7);
    exp_c.delete();
    exp_d.delete();
    cap_c.delete();
    cap_d.delete();
    done_c.delete();
  endtask

  initial begin
    in_nrst = 1'b0;
    frame_start = 1'b0;
    pix.pix_valid = 1'b1;
    pix.pix_rgb1 = 24'h0;
    pix.pix_rgb2 = 24'h0;
    #12;
    check("rst_nwe", fifo_nwe, 1'b1);
    check("rst_nwrst", fifo_nwrst, 1'b1);
    check("rst_data", fifo_data, 8'h00);
    check("rst_ready", pix.pix_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    in_nrst = 1'b1;
    repeat (3) begin
      @(posedge in_clk); #1;
      check("idle_ready", pix.pix_ready, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_nwe", fifo_nwe, 1'b1);
    end

    run_frame(1'b0, 1'b0, 24'h332211, 24'h665544);
    run_frame(1'b1, 1'b0, 24'($urandom), 24'($urandom));
    run_frame(1'b0, 1'b1, 24'($urandom), 24'($urandom));
    run_frame(1'b0, 1'b0, 24'($urandom), 24'($urandom));
    run_frame(1'b1, 1'b0, 24'($urandom), 24'($urandom));

    // Reset in the middle of a pair must raise /WE without waiting for a clock edge.
    frame_start = 1'b1;
    pix.pix_valid = 1'b1;
    @(posedge in_clk); #1;
    frame_start = 1'b0;
    repeat (6) @(posedge in_clk);
    #2;
    check("nwe_before_reset", fifo_nwe, 1'b0);
    in_nrst = 1'b0;
    #1;
    check("async_rst_nwe", fifo_nwe, 1'b1);
    check("async_rst_nwrst", fifo_nwrst, 1'b1);
    check("async_rst_data", fifo_data, 8'h00);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_ready", pix.pix_ready, 1'b0);
    check("async_rst_done", frame_done, 1'b0);
    #3;
    in_nrst = 1'b1;
    repeat (2) @(posedge in_clk);
    #1;
    check("post_rst_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
